ifu_fetch: RTL

Instruction fetch unit at the head of the l2 core pipeline. Holds the architectural PC and issues one instruction-memory read at a time over a request/grant/response interface. Presents each fetched instruction and its PC to the decode stage with the `sys_valid`/`sys_ready` handshake, and accepts jump redirects from the execute stage (`jmp_en`/`jmp_pc`), squashing any younger in-flight or held fetch.

---
 rtl/ifu_fetch_if.sv | 30 +++
 rtl/ifu_fetch.sv | 80 ++++++++
 2 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/grant/response, decode
// handshake and execute-stage redirect.
interface ifu_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  o_ifu_mem_req;
  logic [ADDR_WIDTH-1:0] o_ifu_mem_addr;
  logic                  i_ifu_mem_gnt;
  logic                  i_ifu_mem_rvalid;
  logic [DATA_WIDTH-1:0] i_ifu_mem_rdata;
  logic                  o_sys_valid;
  logic                  i_sys_ready;
  logic [ADDR_WIDTH-1:0] o_ifu_pc;
  logic [DATA_WIDTH-1:0] o_ifu_inst;
  logic                  i_exu_jmp_en;
  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc;

  modport master (
    output o_ifu_mem_req, o_ifu_mem_addr, o_sys_valid, o_ifu_pc, o_ifu_inst,
    input  i_ifu_mem_gnt, i_ifu_mem_rvalid, i_ifu_mem_rdata, i_sys_ready,
           i_exu_jmp_en, i_exu_jmp_pc
  );

  modport slave (
    input  o_ifu_mem_req, o_ifu_mem_addr, o_sys_valid, o_ifu_pc, o_ifu_inst,
    output i_ifu_mem_gnt, i_ifu_mem_rvalid, i_ifu_mem_rdata, i_sys_ready,
           i_exu_jmp_en, i_exu_jmp_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps one memory read in flight, holds the
// fetched instruction for decode and honours execute-stage redirects.
module ifu_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  ifu_fetch_if.master bus
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] KILL  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] jmp_tgt;
  logic [ADDR_WIDTH-1:0] pc_seq;
  logic [DATA_WIDTH-1:0] inst;

  assign jmp_tgt = {bus.i_exu_jmp_pc[ADDR_WIDTH-1:2], 2'b00};
  assign pc_seq  = pc + ADDR_WIDTH'(4);

  // KILL parks the FSM until the response owned by the pre-redirect PC drains,
  // so that stale data can never be mistaken for the new target's instruction.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      inst  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.i_exu_jmp_en) begin
            pc <= jmp_tgt;
            if (bus.i_ifu_mem_gnt) state <= KILL;
          end else if (bus.i_ifu_mem_gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.i_ifu_mem_rvalid) begin
            if (bus.i_exu_jmp_en) begin
              pc    <= jmp_tgt;
              state <= FETCH;
            end else begin
              inst  <= bus.i_ifu_mem_rdata;
              state <= HOLD;
            end
          end else if (bus.i_exu_jmp_en) begin
            pc    <= jmp_tgt;
            state <= KILL;
          end
        end
        KILL: begin
          if (bus.i_exu_jmp_en)     pc    <= jmp_tgt;
          if (bus.i_ifu_mem_rvalid) state <= FETCH;
        end
        HOLD: begin
          if (bus.i_exu_jmp_en) begin
            pc    <= jmp_tgt;
            state <= FETCH;
          end else if (bus.i_sys_ready) begin
            pc    <= pc_seq;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.o_ifu_mem_req  = (state == FETCH) && !i_sys_rst;
  assign bus.o_ifu_mem_addr = pc;
  assign bus.o_ifu_pc       = pc;
  assign bus.o_ifu_inst     = inst;
  assign bus.o_sys_valid    = (state == HOLD);
endmodule
